mem_stage: RTL and testbench



---
 rtl/mem_stage.sv | 170 +++++++++++++++++
 tb/tb_mem_stage.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - MEM pipeline stage: waits for load data, extracts/extends it, drops stale responses
module mem_stage #(
  parameter int ES2MS_LEN = 160
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 es2ms_valid,
  output logic                 ms_allowin,
  input  logic [ES2MS_LEN-1:0] es2ms_bus,
  input  logic [38:0]          es_rf_zip,
  input  logic [4:0]           es_mem_zip,
  input  logic                 es_has_ex,
  input  logic                 data_sram_data_ok,
  input  logic [31:0]          data_sram_rdata,
  output logic                 ms2ws_valid,
  input  logic                 ws_allowin,
  output logic [ES2MS_LEN-1:0] ms2ws_bus,
  output logic [38:0]          ms_rf_zip,
  output logic [38:0]          ms_fwd_zip,
  output logic                 ms_ex,
  input  logic                 wb_ex,
  input  logic                 ertn_flush,
  input  logic                 wb_refetch_flush
);

  logic                 ms_valid_q, ms_valid_d;
  logic [ES2MS_LEN-1:0] bus_q, bus_d;
  logic [38:0]          rf_zip_q, rf_zip_d;
  logic [4:0]           mem_zip_q, mem_zip_d;
  logic                 has_ex_q, has_ex_d;
  logic                 buf_valid_q, buf_valid_d;
  logic [31:0]          buf_data_q, buf_data_d;
  logic [1:0]           discard_cnt_q, discard_cnt_d;

  logic        flush;
  logic        load_en;
  logic        need_data;
  logic        data_ok_acc;
  logic        ms_ready_go;
  logic        ms_leave;
  logic        ms_data_pending;
  logic        cnt_inc;
  logic        cnt_dec;

  logic        csr_re;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] alu_result;
  logic        is_load;
  logic [1:0]  ld_size;
  logic        ld_unsigned;
  logic        req_issued;

  logic [31:0] ld_raw;
  logic [1:0]  off;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_data;
  logic [31:0] final_wdata;

  assign {csr_re, rf_we, rf_waddr, alu_result}            = rf_zip_q;
  assign {is_load, ld_size, ld_unsigned, req_issued}       = mem_zip_q;

  assign flush           = wb_ex | ertn_flush | wb_refetch_flush;
  assign need_data       = ms_valid_q & req_issued & ~has_ex_q;
  // A response is only ours once every stale one has been swallowed.
  assign data_ok_acc     = data_sram_data_ok & (discard_cnt_q == 2'd0);
  assign ms_ready_go     = ~need_data | buf_valid_q | data_ok_acc;
  assign ms_allowin      = ~ms_valid_q | (ms_ready_go & ws_allowin);
  assign ms2ws_valid     = ms_valid_q & ms_ready_go & ~flush;
  assign ms_leave        = ms2ws_valid & ws_allowin;
  assign ms_data_pending = need_data & ~ms_ready_go;
  assign load_en         = es2ms_valid & ms_allowin;

  assign cnt_inc = flush & need_data & ~buf_valid_q & ~data_sram_data_ok;
  assign cnt_dec = data_sram_data_ok & (discard_cnt_q != 2'd0);

  always_comb begin
    ms_valid_d = ms_valid_q;
    if (flush) begin
      ms_valid_d = 1'b0;
    end else if (ms_allowin) begin
      ms_valid_d = es2ms_valid;
    end
  end

  always_comb begin
    bus_d     = bus_q;
    rf_zip_d  = rf_zip_q;
    mem_zip_d = mem_zip_q;
    has_ex_d  = has_ex_q;
    if (load_en) begin
      bus_d     = es2ms_bus;
      rf_zip_d  = es_rf_zip;
      mem_zip_d = es_mem_zip;
      has_ex_d  = es_has_ex;
    end
  end

  // Hold the response only when WB stalls; otherwise rdata flows straight through.
  always_comb begin
    buf_valid_d = buf_valid_q;
    buf_data_d  = buf_data_q;
    if (flush || ms_leave) begin
      buf_valid_d = 1'b0;
    end else if (data_ok_acc && need_data && !buf_valid_q && !ws_allowin) begin
      buf_valid_d = 1'b1;
      buf_data_d  = data_sram_rdata;
    end
  end

  always_comb begin
    discard_cnt_d = discard_cnt_q;
    case ({cnt_inc, cnt_dec})
      2'b10:   discard_cnt_d = (discard_cnt_q == 2'd3) ? 2'd3 : discard_cnt_q + 2'd1;
      2'b01:   discard_cnt_d = discard_cnt_q - 2'd1;
      default: discard_cnt_d = discard_cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ms_valid_q    <= 1'b0;
      bus_q         <= '0;
      rf_zip_q      <= '0;
      mem_zip_q     <= '0;
      has_ex_q      <= 1'b0;
      buf_valid_q   <= 1'b0;
      buf_data_q    <= '0;
      discard_cnt_q <= '0;
    end else begin
      ms_valid_q    <= ms_valid_d;
      bus_q         <= bus_d;
      rf_zip_q      <= rf_zip_d;
      mem_zip_q     <= mem_zip_d;
      has_ex_q      <= has_ex_d;
      buf_valid_q   <= buf_valid_d;
      buf_data_q    <= buf_data_d;
      discard_cnt_q <= discard_cnt_d;
    end
  end

  assign ld_raw = buf_valid_q ? buf_data_q : data_sram_rdata;
  assign off    = alu_result[1:0];

  always_comb begin
    ld_byte = ld_raw[7:0];
    case (off)
      2'd0: ld_byte = ld_raw[7:0];
      2'd1: ld_byte = ld_raw[15:8];
      2'd2: ld_byte = ld_raw[23:16];
      2'd3: ld_byte = ld_raw[31:24];
      default: ld_byte = ld_raw[7:0];
    endcase
    ld_half = off[1] ? ld_raw[31:16] : ld_raw[15:0];
    case (ld_size)
      2'b00:   ld_data = {{24{~ld_unsigned & ld_byte[7]}}, ld_byte};
      2'b01:   ld_data = {{16{~ld_unsigned & ld_half[15]}}, ld_half};
      default: ld_data = ld_raw;
    endcase
  end

  assign final_wdata = is_load ? ld_data : alu_result;

  assign ms2ws_bus  = bus_q;
  assign ms_rf_zip  = {csr_re, rf_we & ms_valid_q, rf_waddr, final_wdata};
  assign ms_fwd_zip = {ms_data_pending, rf_we & ms_valid_q, rf_waddr, final_wdata};
  assign ms_ex      = ms_valid_q & has_ex_q;

endmodule

// File: tb/tb_mem_stage.sv
// tb/tb_mem_stage.sv - bench for mem_stage: directed scenarios plus random traffic against a reference model
module tb_mem_stage;

  logic         clk;
  logic         resetn;
  logic         es2ms_valid;
  logic         ms_allowin;
  logic [159:0] es2ms_bus;
  logic [38:0]  es_rf_zip;
  logic [4:0]   es_mem_zip;
  logic         es_has_ex;
  logic         data_sram_data_ok;
  logic [31:0]  data_sram_rdata;
  logic         ms2ws_valid;
  logic         ws_allowin;
  logic [159:0] ms2ws_bus;
  logic [38:0]  ms_rf_zip;
  logic [38:0]  ms_fwd_zip;
  logic         ms_ex;
  logic         wb_ex;
  logic         ertn_flush;
  logic         wb_refetch_flush;

  int checks;
  int errors;

  // Reference model of the instruction sitting in MEM
  logic         m_occ;
  logic [159:0] m_bus;
  logic [38:0]  m_rf;
  logic [4:0]   m_mem;
  logic         m_hex;
  logic         m_have;
  logic [31:0]  m_data;
  int           m_stale;

  mem_stage #(.ES2MS_LEN(160)) dut (
    .clk               (clk),
    .resetn            (resetn),
    .es2ms_valid       (es2ms_valid),
    .ms_allowin        (ms_allowin),
    .es2ms_bus         (es2ms_bus),
    .es_rf_zip         (es_rf_zip),
    .es_mem_zip        (es_mem_zip),
    .es_has_ex         (es_has_ex),
    .data_sram_data_ok (data_sram_data_ok),
    .data_sram_rdata   (data_sram_rdata),
    .ms2ws_valid       (ms2ws_valid),
    .ws_allowin        (ws_allowin),
    .ms2ws_bus         (ms2ws_bus),
    .ms_rf_zip         (ms_rf_zip),
    .ms_fwd_zip        (ms_fwd_zip),
    .ms_ex             (ms_ex),
    .wb_ex             (wb_ex),
    .ertn_flush        (ertn_flush),
    .wb_refetch_flush  (wb_refetch_flush)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [38:0] rfz(input logic we, input logic [4:0] wa, input logic [31:0] alu);
    return {1'b0, we, wa, alu};
  endfunction

  function automatic logic [4:0] memz(input logic ld, input logic [1:0] sz, input logic uns, input logic req);
    return {ld, sz, uns, req};
  endfunction

  function automatic logic [31:0] load_value(input logic [31:0] raw, input logic [1:0] off,
                                             input logic [1:0] size, input logic uns);
    logic [31:0] v;
    if (size == 2'd0) begin
      v = (raw >> (8 * off)) & 32'hFF;
      if (!uns && v >= 32'd128) v = v - 32'd256;
    end else if (size == 2'd1) begin
      v = (raw >> (16 * off[1])) & 32'hFFFF;
      if (!uns && v >= 32'h8000) v = v - 32'h10000;
    end else begin
      v = raw;
    end
    return v;
  endfunction

  task automatic model_reset();
    m_occ = 0; m_bus = '0; m_rf = '0; m_mem = '0; m_hex = 0;
    m_have = 0; m_data = '0; m_stale = 0;
  endtask

  task automatic idle_inputs();
    es2ms_valid = 0; es2ms_bus = '0; es_rf_zip = '0; es_mem_zip = '0; es_has_ex = 0;
    data_sram_data_ok = 0; data_sram_rdata = '0; ws_allowin = 1;
    wb_ex = 0; ertn_flush = 0; wb_refetch_flush = 0;
  endtask

  // Compare outputs against the model at the falling edge, then advance the model past the next rising edge.
  task automatic step();
    logic        flush, waiting, accepted, ready, leaving, exp_v, exp_allowin;
    logic [31:0] raw, wd;
    @(negedge clk);
    flush       = wb_ex | ertn_flush | wb_refetch_flush;
    waiting     = m_occ && m_mem[0] && !m_hex;
    accepted    = data_sram_data_ok && (m_stale == 0);
    ready       = !waiting || m_have || accepted;
    raw         = m_have ? m_data : data_sram_rdata;
    wd          = m_mem[4] ? load_value(raw, m_rf[1:0], m_mem[3:2], m_mem[1]) : m_rf[31:0];
    exp_allowin = !m_occ || (ready && ws_allowin);
    exp_v       = m_occ && ready && !flush;
    check_eq("allowin", ms_allowin, exp_allowin);
    check_eq("ms2ws_valid", ms2ws_valid, exp_v);
    check_eq("ms_ex", ms_ex, m_occ && m_hex);
    check_eq("rf_zip", ms_rf_zip, {m_rf[38], m_rf[37] & m_occ, m_rf[36:32], wd});
    check_eq("fwd_zip", ms_fwd_zip, {waiting && !ready, m_rf[37] & m_occ, m_rf[36:32], wd});
    check_eq("bus", ms2ws_bus, m_bus);

    leaving = exp_v && ws_allowin;
    if (data_sram_data_ok && m_stale > 0) m_stale--;
    if (flush && waiting && !m_have && !data_sram_data_ok && m_stale < 3) m_stale++;
    if (flush || leaving) m_have = 0;
    else if (accepted && waiting && !m_have) begin
      m_have = 1;
      m_data = data_sram_rdata;
    end
    if (es2ms_valid && exp_allowin) begin
      m_bus = es2ms_bus; m_rf = es_rf_zip; m_mem = es_mem_zip; m_hex = es_has_ex;
    end
    if (flush) m_occ = 0;
    else if (exp_allowin) m_occ = es2ms_valid;
    @(posedge clk);
    #1;
  endtask

  task automatic enter(input logic [31:0] alu, input logic [4:0] mz);
    es2ms_valid = 1;
    es2ms_bus   = {$urandom, $urandom, $urandom, $urandom, $urandom};
    es_rf_zip   = rfz(1'b1, 5'd7, alu);
    es_mem_zip  = mz;
    step();
    es2ms_valid = 0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    resetn = 0;
    idle_inputs();
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_valid", ms2ws_valid, 1'b0);
    check_eq("rst_ex", ms_ex, 1'b0);
    check_eq("rst_rfzip", ms_rf_zip, 39'd0);
    check_eq("rst_fwdzip", ms_fwd_zip, 39'd0);
    check_eq("rst_allowin", ms_allowin, 1'b1);
    resetn = 1;

    // Non-memory op, then a back-to-back stream
    enter(32'h1234, 5'b0);
    #1;
    check_eq("alu_valid", ms2ws_valid, 1'b1);
    check_eq("alu_wdata", ms_rf_zip[31:0], 32'h1234);
    for (int i = 0; i < 4; i++) begin
      es2ms_valid = 1;
      es_rf_zip   = rfz(1'b1, 5'd3, 32'h100 + i);
      es_mem_zip  = '0;
      step();
      check_eq("b2b_valid", ms2ws_valid, 1'b1);
      check_eq("b2b_wdata", ms_rf_zip[31:0], 32'h100 + i);
    end
    es2ms_valid = 0;

    // lb, off=3, response two cycles late
    enter(32'h0000_1003, memz(1'b1, 2'd0, 1'b0, 1'b1));
    for (int i = 0; i < 2; i++) begin
      #1;
      check_eq("lb_pending", ms_fwd_zip[38], 1'b1);
      check_eq("lb_stall", ms2ws_valid, 1'b0);
      step();
    end
    data_sram_data_ok = 1;
    data_sram_rdata   = 32'h8000_0000;
    #1;
    check_eq("lb_valid", ms2ws_valid, 1'b1);
    check_eq("lb_wdata", ms_rf_zip[31:0], 32'hFFFF_FF80);
    step();
    data_sram_data_ok = 0;

    // ld.hu, off=2
    enter(32'h0000_1002, memz(1'b1, 2'd1, 1'b1, 1'b1));
    data_sram_data_ok = 1;
    data_sram_rdata   = 32'hBEEF_0000;
    #1;
    check_eq("lhu_wdata", ms_rf_zip[31:0], 32'h0000_BEEF);
    step();
    data_sram_data_ok = 0;

    // ld.w with WB stalled when the response arrives
    enter(32'h0000_2000, memz(1'b1, 2'd2, 1'b0, 1'b1));
    ws_allowin        = 0;
    data_sram_data_ok = 1;
    data_sram_rdata   = 32'hCAFE_F00D;
    step();
    data_sram_data_ok = 0;
    data_sram_rdata   = 32'h0BAD_0BAD;
    #1;
    check_eq("buf_valid", dut.buf_valid_q, 1'b1);
    check_eq("buf_wdata", ms_rf_zip[31:0], 32'hCAFE_F00D);
    step();
    step();
    ws_allowin = 1;
    #1;
    check_eq("buf_out_valid", ms2ws_valid, 1'b1);
    check_eq("buf_out_wdata", ms_rf_zip[31:0], 32'hCAFE_F00D);
    step();

    // Flush while waiting, stale response then own response
    enter(32'h0000_3000, memz(1'b1, 2'd2, 1'b0, 1'b1));
    wb_ex = 1;
    step();
    wb_ex = 0;
    #1;
    check_eq("flush_allowin", ms_allowin, 1'b1);
    check_eq("flush_cnt", dut.discard_cnt_q, 2'd1);
    enter(32'h0000_3004, memz(1'b1, 2'd2, 1'b0, 1'b1));
    data_sram_data_ok = 1;
    data_sram_rdata   = 32'h1111;
    #1;
    check_eq("stale_ignored", ms2ws_valid, 1'b0);
    check_eq("stale_pending", ms_fwd_zip[38], 1'b1);
    step();
    data_sram_rdata = 32'h2222;
    #1;
    check_eq("own_valid", ms2ws_valid, 1'b1);
    check_eq("own_wdata", ms_rf_zip[31:0], 32'h2222);
    step();
    data_sram_data_ok = 0;

    // Exception with request issued: no wait
    es_has_ex = 1;
    enter(32'h0000_4000, memz(1'b1, 2'd2, 1'b0, 1'b1));
    es_has_ex = 0;
    #1;
    check_eq("ex_ms_ex", ms_ex, 1'b1);
    check_eq("ex_valid", ms2ws_valid, 1'b1);
    step();

    // Build discard_cnt=2, then reset mid-wait
    enter(32'h0000_5000, memz(1'b1, 2'd2, 1'b0, 1'b1));
    ertn_flush = 1;
    step();
    ertn_flush = 0;
    enter(32'h0000_5004, memz(1'b1, 2'd2, 1'b0, 1'b1));
    wb_refetch_flush = 1;
    step();
    wb_refetch_flush = 0;
    enter(32'h0000_5008, memz(1'b1, 2'd2, 1'b0, 1'b1));
    check_eq("cnt_two", dut.discard_cnt_q, 2'd2);
    resetn = 0;
    #1;
    check_eq("mid_rst_valid", ms2ws_valid, 1'b0);
    check_eq("mid_rst_rfzip", ms_rf_zip, 39'd0);
    check_eq("mid_rst_fwdzip", ms_fwd_zip, 39'd0);
    check_eq("mid_rst_ex", ms_ex, 1'b0);
    check_eq("mid_rst_cnt", dut.discard_cnt_q, 2'd0);
    model_reset();
    @(posedge clk);
    #1;
    resetn = 1;
    enter(32'h0000_6000, memz(1'b1, 2'd2, 1'b0, 1'b1));
    data_sram_data_ok = 1;
    data_sram_rdata   = 32'h5A5A_A5A5;
    #1;
    check_eq("post_rst_valid", ms2ws_valid, 1'b1);
    check_eq("post_rst_wdata", ms_rf_zip[31:0], 32'h5A5A_A5A5);
    step();
    data_sram_data_ok = 0;

    // Random traffic; the bench plays the memory and only responds to outstanding requests
    for (int c = 0; c < 3000; c++) begin
      logic waiting;
      waiting           = m_occ && m_mem[0] && !m_hex && !m_have;
      es2ms_valid       = ($urandom_range(0, 9) < 7);
      es2ms_bus         = {$urandom, $urandom, $urandom, $urandom, $urandom};
      es_rf_zip         = 39'({$urandom, $urandom});
      es_has_ex         = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 1) == 1)
        es_mem_zip = memz(1'b1, 2'($urandom_range(0, 2)), 1'($urandom), 1'b1);
      else
        es_mem_zip = memz(1'b0, 2'd0, 1'b0, 1'b0);
      data_sram_rdata   = $urandom;
      data_sram_data_ok = (m_stale > 0 || waiting) && ($urandom_range(0, 9) < 4);
      ws_allowin        = ($urandom_range(0, 3) != 0);
      wb_ex             = 0;
      ertn_flush        = 0;
      wb_refetch_flush  = 0;
      if (m_stale < 2 && $urandom_range(0, 99) < 8) begin
        case ($urandom_range(0, 2))
          0: wb_ex = 1;
          1: ertn_flush = 1;
          default: wb_refetch_flush = 1;
        endcase
      end
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
